mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/cpu_pkg.sv | 18 +
 rtl/mem_access_timer.sv | 33 +++
 rtl/mem_access.sv | 140 ++++++++++++++
 tb/tb_mem_access.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode fields, the bubble instruction and the
// memory-stage FSM state type.
package cpu_pkg;

   localparam logic [1:0]  OP_LOAD  = 2'b10;
   localparam logic [1:0]  OP_STORE = 2'b11;
   localparam logic [15:0] INSN_NOP = 16'h0000;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   function automatic logic is_mem_op(input logic [15:0] insn);
      return (insn[15:14] == OP_LOAD) || (insn[15:14] == OP_STORE);
   endfunction

endpackage

// File: rtl/mem_access_timer.sv
// Wait counter for an outstanding memory request.
// Ports: clk, rst (async, active-high), clear (restart count),
//        enable (count this cycle), expired (this cycle is the TIMEOUT-th).
module mem_access_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + W'(1);
      end
   end

   // r_count holds the number of waits already completed, so the
   // TIMEOUT-th waiting cycle is the one where it equals TIMEOUT-1.
   assign expired = enable && (r_count == LIMIT);

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes non-memory instructions through,
// issues one load/store at a time to memory and stalls upstream until
// the ack (or a timeout, which drops the instruction and sets fault).
// Ports: clk, rst; m_* upstream instruction and m_stall back-pressure;
//        mem_* memory request/response; w_insn writeback instruction;
//        mem_ro_port_value last load result; fault sticky timeout flag.
module mem_access
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_valid,
   input  logic [15:0] m_insn,
   input  logic [15:0] m_addr,
   input  logic [15:0] m_data,
   output logic        m_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [15:0] w_insn,
   output logic [15:0] mem_ro_port_value,
   output logic        fault
);

   mem_state_t r_state;
   mem_state_t w_next_state;

   logic        r_req;
   logic        r_we;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_insn;
   logic [15:0] r_winsn;
   logic [15:0] r_ro;
   logic        r_fault;

   logic w_is_mem;
   logic w_accept;
   logic w_busy;
   logic w_expired;

   assign w_is_mem = is_mem_op(m_insn);
   assign w_busy   = (r_state == BUSY);
   assign w_accept = !w_busy && m_valid && w_is_mem;

   mem_access_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_accept),
      .enable  (w_busy),
      .expired (w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Ack takes priority over expiry in the same cycle.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next_state = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack || w_expired) begin
               w_next_state = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_insn  <= INSN_NOP;
         r_winsn <= INSN_NOP;
         r_ro    <= '0;
         r_fault <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (m_valid && !w_is_mem) begin
                  r_winsn <= m_insn;
               end else begin
                  r_winsn <= INSN_NOP;
               end
               if (w_accept) begin
                  r_req   <= 1'b1;
                  r_we    <= m_insn[14];
                  r_addr  <= m_addr;
                  r_wdata <= m_data;
                  r_insn  <= m_insn;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  r_req   <= 1'b0;
                  r_winsn <= r_insn;
                  if (r_insn[15:14] == OP_LOAD) begin
                     r_ro <= mem_rdata;
                  end
               end else if (w_expired) begin
                  r_req   <= 1'b0;
                  r_fault <= 1'b1;
                  r_winsn <= INSN_NOP;
               end else begin
                  r_winsn <= INSN_NOP;
               end
            end
         endcase
      end
   end

   assign m_stall           = w_busy;
   assign mem_req           = r_req;
   assign mem_we            = r_we;
   assign mem_addr          = r_addr;
   assign mem_wdata         = r_wdata;
   assign w_insn            = r_winsn;
   assign mem_ro_port_value = r_ro;
   assign fault             = r_fault;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: two instances (TIMEOUT 4 and 2) share stimulus;
// a behavioural model checks both every cycle, plus literal checks.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        m_valid = 1'b0;
   logic [15:0] m_insn = '0;
   logic [15:0] m_addr = '0;
   logic [15:0] m_data = '0;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;

   logic [1:0]       o_stall, o_req, o_we, o_fault;
   logic [1:0][15:0] o_addr, o_wdata, o_winsn, o_ro;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   mem_access #(.TIMEOUT(4)) u_a (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_insn(m_insn),
      .m_addr(m_addr), .m_data(m_data),
      .m_stall(o_stall[0]), .mem_req(o_req[0]),
      .mem_we(o_we[0]), .mem_addr(o_addr[0]),
      .mem_wdata(o_wdata[0]), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .w_insn(o_winsn[0]),
      .mem_ro_port_value(o_ro[0]), .fault(o_fault[0])
   );

   mem_access #(.TIMEOUT(2)) u_b (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_insn(m_insn),
      .m_addr(m_addr), .m_data(m_data),
      .m_stall(o_stall[1]), .mem_req(o_req[1]),
      .mem_we(o_we[1]), .mem_addr(o_addr[1]),
      .mem_wdata(o_wdata[1]), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .w_insn(o_winsn[1]),
      .mem_ro_port_value(o_ro[1]), .fault(o_fault[1])
   );

   // Model: an outstanding op record plus the visible results.
   int          tmo [2] = '{4, 2};
   bit          p_busy [2];
   int          p_wait [2];
   logic [15:0] p_insn [2];
   logic        e_req [2];
   logic        e_we [2];
   logic        e_fault [2];
   logic [15:0] e_addr [2];
   logic [15:0] e_wdata [2];
   logic [15:0] e_winsn [2];
   logic [15:0] e_ro [2];

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            p_busy[k]  <= 1'b0;
            p_wait[k]  <= 0;
            p_insn[k]  <= '0;
            e_req[k]   <= 1'b0;
            e_we[k]    <= 1'b0;
            e_fault[k] <= 1'b0;
            e_addr[k]  <= '0;
            e_wdata[k] <= '0;
            e_winsn[k] <= '0;
            e_ro[k]    <= '0;
         end else if (!p_busy[k]) begin
            if (m_valid && m_insn[15]) begin
               p_busy[k]  <= 1'b1;
               p_wait[k]  <= 0;
               p_insn[k]  <= m_insn;
               e_req[k]   <= 1'b1;
               e_we[k]    <= m_insn[14];
               e_addr[k]  <= m_addr;
               e_wdata[k] <= m_data;
               e_winsn[k] <= '0;
            end else begin
               e_winsn[k] <= m_valid ? m_insn : 16'h0000;
            end
         end else begin
            p_wait[k] <= p_wait[k] + 1;
            if (mem_ack) begin
               p_busy[k]  <= 1'b0;
               e_req[k]   <= 1'b0;
               e_winsn[k] <= p_insn[k];
               if (p_insn[k][15:14] == 2'b10)
                  e_ro[k] <= mem_rdata;
            end else if (p_wait[k] + 1 == tmo[k]) begin
               p_busy[k]  <= 1'b0;
               e_req[k]   <= 1'b0;
               e_winsn[k] <= '0;
               e_fault[k] <= 1'b1;
            end else begin
               e_winsn[k] <= '0;
            end
         end
      end
   end

   task automatic chk(input string name,
                      input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("stall%0d", k), o_stall[k], p_busy[k]);
            chk($sformatf("req%0d", k), o_req[k], e_req[k]);
            chk($sformatf("winsn%0d", k), o_winsn[k], e_winsn[k]);
            chk($sformatf("ro%0d", k), o_ro[k], e_ro[k]);
            chk($sformatf("fault%0d", k), o_fault[k], e_fault[k]);
            if (e_req[k]) begin
               chk($sformatf("we%0d", k), o_we[k], e_we[k]);
               chk($sformatf("addr%0d", k), o_addr[k], e_addr[k]);
               chk($sformatf("wdata%0d", k), o_wdata[k], e_wdata[k]);
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [15:0] i,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic ack, input logic [15:0] rd);
      m_valid   = v;
      m_insn    = i;
      m_addr    = a;
      m_data    = d;
      mem_ack   = ack;
      mem_rdata = rd;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
   endtask

   initial begin
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_on = 1'b1;
      chk("rst_winsn", o_winsn[0], 16'h0000);
      chk("rst_req", o_req[0], 16'h0);
      chk("rst_addr", o_addr[0], 16'h0000);
      chk("rst_ro", o_ro[0], 16'h0000);
      chk("rst_fault", o_fault[0], 16'h0);

      // non-memory pass-through, then bubble
      drive(1'b1, 16'h1234, 16'h0, 16'h0, 1'b0, 16'h0);
      chk("nm_winsn", o_winsn[0], 16'h1234);
      chk("nm_stall", o_stall[0], 16'h0);
      chk("nm_req", o_req[0], 16'h0);
      idle(1);
      chk("bubble", o_winsn[0], 16'h0000);
      idle(2);

      // load, ack on third BUSY cycle; garbage inputs while busy
      drive(1'b1, 16'h8400, 16'h0010, 16'h0, 1'b0, 16'h0);
      chk("ld_req1", o_req[0], 16'h1);
      chk("ld_addr", o_addr[0], 16'h0010);
      chk("ld_we", o_we[0], 16'h0);
      drive(1'b1, 16'h1111, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0);
      chk("ld_req2", o_req[0], 16'h1);
      chk("ld_addr_hold", o_addr[0], 16'h0010);
      drive(1'b1, 16'h1111, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0);
      chk("ld_req3", o_req[0], 16'h1);
      drive(1'b1, 16'h1111, 16'hFFFF, 16'hFFFF, 1'b1, 16'hBEEF);
      chk("ld_req_off", o_req[0], 16'h0);
      chk("ld_winsn", o_winsn[0], 16'h8400);
      chk("ld_ro", o_ro[0], 16'hBEEF);
      chk("ld_b_fault", o_fault[1], 16'h1);
      idle(3);

      // store with immediate ack
      drive(1'b1, 16'hC000, 16'h0020, 16'h5A5A, 1'b0, 16'h0);
      chk("st_we", o_we[0], 16'h1);
      chk("st_wdata", o_wdata[0], 16'h5A5A);
      chk("st_addr", o_addr[0], 16'h0020);
      drive(1'b1, 16'hC000, 16'h0020, 16'h5A5A, 1'b1, 16'h7777);
      chk("st_winsn", o_winsn[0], 16'hC000);
      chk("st_ro", o_ro[0], 16'hBEEF);
      chk("st_req_off", o_req[0], 16'h0);
      idle(3);

      // timeout: TIMEOUT=4, no ack
      drive(1'b1, 16'h8800, 16'h0030, 16'h0, 1'b0, 16'h0);
      for (int n = 0; n < 3; n++) begin
         drive(1'b1, 16'h8800, 16'h0030, 16'h0, 1'b0, 16'h0);
         chk("to_req_held", o_req[0], 16'h1);
      end
      drive(1'b1, 16'h8800, 16'h0030, 16'h0, 1'b0, 16'h0);
      chk("to_req_off", o_req[0], 16'h0);
      chk("to_fault", o_fault[0], 16'h1);
      chk("to_winsn", o_winsn[0], 16'h0000);
      drive(1'b1, 16'h2345, 16'h0, 16'h0, 1'b0, 16'h0);
      chk("to_nm_winsn", o_winsn[0], 16'h2345);
      chk("to_fault_sticky", o_fault[0], 16'h1);
      idle(3);

      // reset mid-BUSY, then stray ack
      drive(1'b1, 16'h8400, 16'h0050, 16'h0, 1'b0, 16'h0);
      drive(1'b1, 16'h8400, 16'h0050, 16'h0, 1'b0, 16'h0);
      #2;
      rst = 1'b1;
      m_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 16'hDEAD);
      for (int k = 0; k < 2; k++) begin
         chk("rs_winsn", o_winsn[k], 16'h0000);
         chk("rs_req", o_req[k], 16'h0);
         chk("rs_stall", o_stall[k], 16'h0);
         chk("rs_ro", o_ro[k], 16'h0000);
         chk("rs_fault", o_fault[k], 16'h0);
         chk("rs_addr", o_addr[k], 16'h0000);
         chk("rs_we", o_we[k], 16'h0);
      end

      // ack coincident with timeout on the TIMEOUT=2 instance
      drive(1'b1, 16'h8C00, 16'h0040, 16'h0, 1'b0, 16'h0);
      drive(1'b1, 16'h8C00, 16'h0040, 16'h0, 1'b0, 16'h0);
      chk("co_req_held", o_req[1], 16'h1);
      drive(1'b1, 16'h8C00, 16'h0040, 16'h0, 1'b1, 16'h1357);
      chk("co_winsn", o_winsn[1], 16'h8C00);
      chk("co_ro", o_ro[1], 16'h1357);
      chk("co_fault", o_fault[1], 16'h0);
      chk("co_req_off", o_req[1], 16'h0);
      idle(2);

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
